// File: rtl/conv_geom_pkg.sv
// Geometry constants, width helpers and state encoding shared by the
// convolution scatter encoder and its hit evaluator.
package conv_geom_pkg;

  localparam int unsigned K_DEF = 3;
  localparam int unsigned N_DEF = 2;

  function automatic int unsigned w_of(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int unsigned IDX_W = w_of(N_DEF * N_DEF * K_DEF * K_DEF);
  localparam int unsigned PIX_W = w_of(N_DEF * N_DEF);
  localparam int unsigned TAP_W = w_of(K_DEF * K_DEF);
  localparam int unsigned STR_W = w_of(K_DEF);
  localparam int unsigned CNT_W = w_of(N_DEF * N_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  // Unsigned window test; the >= checks guard the subtractions.
  function automatic logic geom_hit(input int unsigned r, input int unsigned c,
                                    input int unsigned s, input int unsigned px,
                                    input int unsigned py, input int unsigned k);
    int unsigned sx;
    int unsigned sy;
    sx = s * px;
    sy = s * py;
    return (r >= sx) && ((r - sx) < k) && (c >= sy) && ((c - sy) < k);
  endfunction

endpackage

// File: rtl/conv_scatter_hit.sv
// Combinational test of one candidate output pixel (px,py) against an input
// location (r,c); yields the kernel tap coordinates when the window covers it.
module conv_scatter_hit
  import conv_geom_pkg::*;
#(
  parameter int unsigned K = K_DEF,
  parameter int unsigned N = N_DEF
) (
  input  logic [$clog2(N*K):0] r,
  input  logic [$clog2(N*K):0] c,
  input  logic [w_of(K)-1:0]   stride,
  input  logic [w_of(N)-1:0]   px,
  input  logic [w_of(N)-1:0]   py,
  output logic                 hit,
  output logic [$clog2(N*K):0] kx,
  output logic [$clog2(N*K):0] ky
);

  localparam int unsigned GW = $clog2(N * K) + 1;

  logic [GW-1:0] sx;
  logic [GW-1:0] sy;

  assign sx = GW'(stride) * GW'(px);
  assign sy = GW'(stride) * GW'(py);

  assign hit = (r >= sx) && ((r - sx) < GW'(K)) &&
               (c >= sy) && ((c - sy) < GW'(K));

  assign kx = r - sx;
  assign ky = c - sy;

endmodule

// File: rtl/conv_scatter_encoder.sv
// Scatter-side inverse of the convolution window mapping: for one input-map
// index, walks all output pixels and emits every (pixel, tap) pair reading it.
module conv_scatter_encoder
  import conv_geom_pkg::*;
#(
  parameter int unsigned K = K_DEF,
  parameter int unsigned N = N_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [w_of(N*N*K*K)-1:0]    in_index,
  input  logic [w_of(K)-1:0]          stride,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [w_of(N*N)-1:0]        pixel_number,
  output logic [w_of(K*K)-1:0]        current_index,
  output logic                        out_last,
  output logic                        done,
  output logic [w_of(N*N+1)-1:0]      hit_count
);

  localparam int unsigned IW = w_of(N * N * K * K);
  localparam int unsigned PW = w_of(N * N);
  localparam int unsigned TW = w_of(K * K);
  localparam int unsigned SW = w_of(K);
  localparam int unsigned CW = w_of(N * N + 1);
  localparam int unsigned XW = w_of(N);
  localparam int unsigned GW = $clog2(N * K) + 1;
  localparam logic [IW-1:0] NK_L = IW'(N * K);

  state_e          state_q, state_d;
  logic [GW-1:0]   r_q, r_d;
  logic [GW-1:0]   c_q, c_d;
  logic [SW-1:0]   s_q, s_d;
  logic [XW-1:0]   px_q, px_d;
  logic [XW-1:0]   py_q, py_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N*N-1:0]  mask_q, mask_d;
  logic            ready_q, ready_d;

  logic            hit;
  logic [GW-1:0]   kx;
  logic [GW-1:0]   ky;
  logic [PW-1:0]   cur_pix;
  logic            later_hit;
  logic            advance;
  logic            handshake;

  conv_scatter_hit #(
    .K (K),
    .N (N)
  ) u_hit (
    .r      (r_q),
    .c      (c_q),
    .stride (s_q),
    .px     (px_q),
    .py     (py_q),
    .hit    (hit),
    .kx     (kx),
    .ky     (ky)
  );

  assign cur_pix = PW'(32'(px_q) * N + 32'(py_q));

  // out_last comes from the mask captured at accept: any hit beyond the
  // current raster position means this pair is not the final one.
  always_comb begin
    later_hit = 1'b0;
    for (int unsigned i = 0; i < N * N; i++) begin
      if ((i > 32'(cur_pix)) && mask_q[i]) later_hit = 1'b1;
    end
  end

  assign handshake = (state_q == SCAN) && hit && out_ready;
  assign advance   = (state_q == SCAN) && (!hit || out_ready);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    s_d     = s_q;
    px_d    = px_q;
    py_d    = py_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          r_d     = GW'(in_index / NK_L);
          c_d     = GW'(in_index % NK_L);
          s_d     = stride;
          px_d    = '0;
          py_d    = '0;
          cnt_d   = '0;
          state_d = SCAN;
          for (int unsigned i = 0; i < N * N; i++) begin
            mask_d[i] = geom_hit(32'(r_d), 32'(c_d), 32'(stride), i / N, i % N, K);
          end
        end
      end
      SCAN: begin
        if (handshake) cnt_d = cnt_q + CW'(1);
        if (advance) begin
          if (py_q == XW'(N - 1)) begin
            py_d = '0;
            if (px_q == XW'(N - 1)) state_d = DONE;
            else px_d = px_q + XW'(1);
          end else begin
            py_d = py_q + XW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      s_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      s_q     <= s_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready      = ready_q;
  assign out_valid     = (state_q == SCAN) && hit;
  assign pixel_number  = out_valid ? cur_pix : '0;
  assign current_index = out_valid ? TW'(TW'(kx) * TW'(K) + TW'(ky)) : '0;
  assign out_last      = out_valid && !later_hit;
  assign done          = (state_q == DONE);
  assign hit_count     = done ? cnt_q : '0;

endmodule

// File: tb/tb_conv_scatter_encoder.sv
// Directed bench for conv_scatter_encoder (K=3, N=2) with hand-derived pairs.
module tb_conv_scatter_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_index = '0;
  logic [1:0] stride = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] pixel_number;
  logic [3:0] current_index;
  logic       out_last;
  logic       done;
  logic [2:0] hit_count;

  int n_vec = 0;
  int n_miss = 0;
  int exp_pix[4];
  int exp_tap[4];
  int exp_n;

  conv_scatter_encoder #(
    .K (3),
    .N (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_index      (in_index),
    .stride        (stride),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .pixel_number  (pixel_number),
    .current_index (current_index),
    .out_last      (out_last),
    .done          (done),
    .hit_count     (hit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_exp(input int n, input int p0, input int t0, input int p1, input int t1,
                         input int p2, input int t2, input int p3, input int t3);
    exp_n = n;
    exp_pix[0] = p0; exp_tap[0] = t0;
    exp_pix[1] = p1; exp_tap[1] = t1;
    exp_pix[2] = p2; exp_tap[2] = t2;
    exp_pix[3] = p3; exp_tap[3] = t3;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_idx(input int idx, input int s, input bit stall, input int done_cyc);
    int   k;
    int   fwd;
    bit   held;
    bit   fin;
    logic [1:0] h_pix;
    logic [3:0] h_tap;
    logic       h_last;
    in_index  = 6'(idx);
    stride    = 2'(s);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    held = 1'b0;
    fin = 1'b0;
    h_pix = '0;
    h_tap = '0;
    h_last = 1'b0;
    for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
      out_ready = stall ? cyc[0] : 1'b1;
      @(negedge clk);
      if (held) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_pix", 32'(pixel_number), 32'(h_pix));
        chk("stall_tap", 32'(current_index), 32'(h_tap));
        chk("stall_last", 32'(out_last), 32'(h_last));
      end
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (k < exp_n) begin
            chk("pair_pix", 32'(pixel_number), 32'(exp_pix[k]));
            chk("pair_tap", 32'(current_index), 32'(exp_tap[k]));
            chk("pair_last", 32'(out_last), (k == exp_n - 1) ? 1 : 0);
            fwd = (int'(current_index) / 3 + s * (int'(pixel_number) / 2)) * 6 +
                  (int'(current_index) % 3 + s * (int'(pixel_number) % 2));
            chk("invariant", 32'(fwd), 32'(idx));
          end else begin
            chk("extra_pair", 32'(k + 1), 32'(exp_n));
          end
          k++;
        end else begin
          held   = 1'b1;
          h_pix  = pixel_number;
          h_tap  = current_index;
          h_last = out_last;
        end
      end
      if (done) begin
        chk("hit_count", 32'(hit_count), 32'(exp_n));
        chk("pairs_seen", 32'(k), 32'(exp_n));
        chk("done_no_valid", 32'(out_valid), 0);
        if (done_cyc > 0) chk("done_cycle", 32'(cyc), 32'(done_cyc));
        fin = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!fin) begin
      chk("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("in_ready_after_done", 32'(in_ready), 1);
      chk("done_pulse_once", 32'(done), 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_pix", 32'(pixel_number), 0);
    chk("rst_tap", 32'(current_index), 0);
    chk("rst_last", 32'(out_last), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    set_exp(1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_idx(0, 1, 1'b0, 5);
    set_exp(4, 0, 4, 1, 3, 2, 1, 3, 0);
    run_idx(7, 1, 1'b0, 5);
    set_exp(4, 0, 8, 1, 6, 2, 2, 3, 0);
    run_idx(14, 2, 1'b0, 5);
    set_exp(1, 0, 4, 0, 0, 0, 0, 0, 0);
    run_idx(7, 3, 1'b0, 5);
    set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_idx(35, 1, 1'b0, 5);
    // stride 0: r=1,c=2 is under every pixel at tap 5
    set_exp(4, 0, 5, 1, 5, 2, 5, 3, 5);
    run_idx(8, 0, 1'b0, 5);
    set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_idx(40, 2, 1'b0, 5);
    set_exp(4, 0, 4, 1, 3, 2, 1, 3, 0);
    run_idx(7, 1, 1'b1, 0);

    in_index  = 6'd7;
    stride    = 2'd1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_tap", 32'(current_index), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_tap", 32'(current_index), 0);
    chk("midrst_pix", 32'(pixel_number), 0);
    chk("midrst_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_exp(1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_idx(0, 1, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
